// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared phase encoding, default duty width and gamma table for the PWM duty path
package pwm_pkg;

    localparam int DUTY_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } phase_e;

    // Entry i lives in bits [4*i +: 4]; entry 0 is the least significant nibble.
    localparam logic [63:0] GAMMA_LUT = {
        4'd15, 4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3,
        4'd2,  4'd2,  4'd1,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
    };

    function automatic logic [3:0] gamma_lookup(input logic [3:0] lin);
        return GAMMA_LUT[int'(lin) * 4 +: 4];
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// rtl/pwm_duty_ramp_if.sv - enable in, duty/phase/period_start out of the duty ramp
interface pwm_duty_ramp_if #(
    parameter int WIDTH = 4
) ();
    logic             enable;
    logic [WIDTH-1:0] duty;
    logic             period_start;
    logic [2:0]       phase;

    modport master (
        output enable,
        input  duty,
        input  period_start,
        input  phase
    );

    modport slave (
        input  enable,
        output duty,
        output period_start,
        output phase
    );
endinterface

// File: rtl/pwm_period_timer.sv
// rtl/pwm_period_timer.sv - 2^WIDTH-cycle period counter shared with the PWM so both agree on boundaries
module pwm_period_timer #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic running,
    output logic tick,
    output logic period_start
);
    logic [WIDTH-1:0] pcnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + WIDTH'(1);
        end
    end

    assign tick         = (pcnt == {WIDTH{1'b1}});
    assign period_start = running && (pcnt == '0);
endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - breathing duty ramp (rise, hold high, fall, hold low); PWM_DUTY_RAMP_GAMMA_EN adds a registered gamma LUT
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH        = DUTY_W,
    parameter int STEP_PERIODS = 2,
    parameter int HOLD_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst,
    pwm_duty_ramp_if.slave   bus
);
    localparam logic [WIDTH-1:0] DMAX      = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [15:0]      STEP_LAST = 16'(STEP_PERIODS - 1);
    localparam logic [15:0]      HOLD_LAST = 16'(HOLD_PERIODS - 1);

    phase_e           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [15:0]      scnt_q, scnt_d, hcnt_q, hcnt_d;
    logic             tick, lin_period_start, running, clear, step, hold_done;

    assign running = (state_q != IDLE);
    // Clear when idle or about to go idle so the first RISE period starts at pcnt=0.
    assign clear   = !running || !bus.enable;

    pwm_period_timer #(.WIDTH(WIDTH)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .running      (running),
        .tick         (tick),
        .period_start (lin_period_start)
    );

    assign step      = tick && (scnt_q == STEP_LAST);
    assign hold_done = tick && (hcnt_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            scnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            scnt_q  <= scnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        scnt_d  = scnt_q;
        hcnt_d  = hcnt_q;
        if (!bus.enable) begin
            state_d = IDLE;
            duty_d  = '0;
            scnt_d  = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RISE;
                    duty_d  = '0;
                    scnt_d  = '0;
                    hcnt_d  = '0;
                end
                RISE: begin
                    if (tick) scnt_d = step ? '0 : scnt_q + 16'd1;
                    if (step) begin
                        duty_d = duty_q + ONE;
                        if (duty_q == DMAX - ONE) begin
                            state_d = HOLD_HI;
                            hcnt_d  = '0;
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) hcnt_d = hold_done ? '0 : hcnt_q + 16'd1;
                    if (hold_done) begin
                        state_d = FALL;
                        scnt_d  = '0;
                    end
                end
                FALL: begin
                    if (tick) scnt_d = step ? '0 : scnt_q + 16'd1;
                    if (step) begin
                        duty_d = duty_q - ONE;
                        if (duty_q == ONE) begin
                            state_d = HOLD_LO;
                            hcnt_d  = '0;
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) hcnt_d = hold_done ? '0 : hcnt_q + 16'd1;
                    if (hold_done) begin
                        state_d = RISE;
                        scnt_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                    scnt_d  = '0;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    assign bus.phase = state_q;

`ifdef PWM_DUTY_RAMP_GAMMA_EN
    if (WIDTH != 4) begin : g_gamma_width_check
        $error("PWM_DUTY_RAMP_GAMMA_EN requires WIDTH == 4");
    end

    logic [WIDTH-1:0] duty_gamma;
    logic             period_start_q;

    // Period start is delayed with the LUT so it still marks the cycle the duty changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_gamma     <= '0;
            period_start_q <= 1'b0;
        end else begin
            duty_gamma     <= gamma_lookup(duty_q);
            period_start_q <= lin_period_start;
        end
    end

    assign bus.duty         = duty_gamma;
    assign bus.period_start = period_start_q;
`else
    assign bus.duty         = duty_q;
    assign bus.period_start = lin_period_start;
`endif
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - randomized enable/reset stimulus against a closed-form ramp model, two parameter sets
module tb_pwm_duty_ramp;
    localparam int W  = 4;
    localparam int L  = 16;
    localparam int DM = 15;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    pwm_duty_ramp_if #(.WIDTH(W)) bus_a ();
    pwm_duty_ramp_if #(.WIDTH(W)) bus_b ();

    assign bus_a.enable = enable;
    assign bus_b.enable = enable;

    pwm_duty_ramp #(.WIDTH(W), .STEP_PERIODS(2), .HOLD_PERIODS(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pwm_duty_ramp #(.WIDTH(W), .STEP_PERIODS(1), .HOLD_PERIODS(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;

    int gtab [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};

    bit running = 1'b0;
    int t       = 0;
    int lin_last_a = 0, lin_last_b = 0, ps_last_a = 0, ps_last_b = 0;
    int duty_prev_a = 0, duty_prev_b = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0d time=%0t)", tag, obs, exp, t, $time);
        end
    endtask

    // Closed form: rise DMAX steps of s periods, hold h periods, fall, hold h periods.
    task automatic ramp_model(input int tt, input int s, input int h, output int d, output int ph);
        int rlen, hlen, u;
        rlen = DM * s * L;
        hlen = h * L;
        u    = tt % (2 * rlen + 2 * hlen);
        if (u < rlen) begin
            ph = 1; d = u / (s * L);
        end else if (u < rlen + hlen) begin
            ph = 2; d = DM;
        end else if (u < 2 * rlen + hlen) begin
            ph = 3; d = DM - (u - rlen - hlen) / (s * L);
        end else begin
            ph = 4; d = 0;
        end
    endtask

    task automatic check_dut(input string n, input int s, input int h,
                             input int duty_obs, input int phase_obs, input int ps_obs,
                             inout int lin_last, inout int ps_last, inout int duty_prev);
        int lin, ph, ps, exp_d, exp_ps;
        if (running) ramp_model(t, s, h, lin, ph);
        else begin
            lin = 0; ph = 0;
        end
        ps = (running && (t % L == 0)) ? 1 : 0;
`ifdef PWM_DUTY_RAMP_GAMMA_EN
        exp_d  = rst ? 0 : gtab[lin_last];
        exp_ps = rst ? 0 : ps_last;
`else
        exp_d  = lin;
        exp_ps = ps;
`endif
        lin_last = lin;
        ps_last  = ps;
        check_val({n, ".duty"}, duty_obs, exp_d);
        check_val({n, ".phase"}, phase_obs, ph);
        check_val({n, ".period_start"}, ps_obs, exp_ps);
        if (running && t > 0 && duty_obs != duty_prev)
            check_val({n, ".duty_change_on_boundary"}, ps_obs, 1);
        duty_prev = duty_obs;
    endtask

    task automatic step_cycle();
        @(posedge clk);
        if (rst || !enable) running = 1'b0;
        else if (!running) begin
            running = 1'b1;
            t = 0;
        end else t++;
        #1;
        check_dut("a", 2, 4, int'(bus_a.duty), int'(bus_a.phase), int'(bus_a.period_start),
                  lin_last_a, ps_last_a, duty_prev_a);
        check_dut("b", 1, 1, int'(bus_b.duty), int'(bus_b.phase), int'(bus_b.period_start),
                  lin_last_b, ps_last_b, duty_prev_b);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        repeat (3) step_cycle();
        rst = 1'b0;
        repeat (3 * 1088 + 40) step_cycle();

        // Mid-ramp disable at t=200 then immediate re-enable.
        enable = 1'b0;
        step_cycle();
        enable = 1'b1;
        repeat (201) step_cycle();
        enable = 1'b0;
        step_cycle();
        enable = 1'b1;
        repeat (40) step_cycle();

        for (int seg = 0; seg < 20; seg++) begin
            if ($urandom_range(0, 4) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) step_cycle();
                rst = 1'b0;
            end
            enable = 1'b0;
            repeat ($urandom_range(1, 4)) step_cycle();
            enable = 1'b1;
            repeat ($urandom_range(1, 700)) step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
